ssd_scan_ctrl: RTL and testbench

Time-multiplexed scan controller for a 4-digit common-anode seven-segment display. It holds a 4-digit BCD frame and rotates through the digits at a programmable refresh rate. For each digit it drives the active-low digit-enable lines and presents that digit's 4-bit code to the downstream combinational SSD decoder. New frames are double-buffered and committed only at a frame boundary, so the display never shows a half-updated value.

---
 rtl/ssd_scan_ctrl.sv | 131 +++++++++++++
 tb/tb_ssd_scan_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/ssd_scan_ctrl.sv
// 4-digit common-anode scan controller with double-buffered frame commit; outputs registered (1 cycle), no backpressure.
// Optional leading-zero blanking under SSD_LEADING_ZERO_BLANK_EN (digit 0 always lit).
module ssd_scan_ctrl #(
  parameter int REFRESH_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        load,
  input  logic [15:0] data_in,
  output logic        busy,
  output logic        load_ack,
  output logic [3:0]  bcd_sel,
  output logic [3:0]  ssd_ctl
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [1:0]       idx;
  logic [1:0]       idx_nxt;
  logic [15:0]      act;
  logic [15:0]      act_nxt;
  logic [15:0]      pend;
  logic [15:0]      pend_nxt;
  logic             pv;
  logic             pv_nxt;
  logic             tick;
  logic             boundary;
  logic             commit;
  logic             blank;
  logic [3:0]       digit_nxt;
  logic [3:0]       sel_nxt;
  logic [3:0]       ctl_nxt;

  assign tick     = en && (cnt == CNT_LAST);
  assign boundary = tick && (idx == 2'd3);
  assign commit   = boundary && (load || pv);
  assign busy     = pv;

  always_comb begin
    cnt_nxt = cnt;
    idx_nxt = idx;
    if (tick) begin
      cnt_nxt = '0;
      idx_nxt = idx + 2'd1;
    end else if (en) begin
      cnt_nxt = cnt + 1'b1;
    end
  end

  // A load landing on the boundary bypasses pend and supersedes any older pending frame.
  always_comb begin
    act_nxt  = act;
    pend_nxt = pend;
    pv_nxt   = pv;
    if (boundary && load) begin
      act_nxt = data_in;
      pv_nxt  = 1'b0;
    end else if (boundary && pv) begin
      act_nxt = pend;
      pv_nxt  = 1'b0;
    end else if (load) begin
      pend_nxt = data_in;
      pv_nxt   = 1'b1;
    end
  end

  always_comb begin
    case (idx_nxt)
      2'd0:    digit_nxt = act_nxt[3:0];
      2'd1:    digit_nxt = act_nxt[7:4];
      2'd2:    digit_nxt = act_nxt[11:8];
      default: digit_nxt = act_nxt[15:12];
    endcase
  end

`ifdef SSD_LEADING_ZERO_BLANK_EN
  always_comb begin
    case (idx_nxt)
      2'd1:    blank = (act_nxt[15:4] == 12'h000);
      2'd2:    blank = (act_nxt[15:8] == 8'h00);
      2'd3:    blank = (act_nxt[15:12] == 4'h0);
      default: blank = 1'b0;
    endcase
  end
`else
  assign blank = 1'b0;
`endif

  // Outputs are computed from next-state so they move on the same edge as idx/act.
  always_comb begin
    sel_nxt = bcd_sel;
    ctl_nxt = 4'b1111;
    if (en) begin
      sel_nxt = digit_nxt;
      case (idx_nxt)
        2'd0:    ctl_nxt = 4'b1110;
        2'd1:    ctl_nxt = 4'b1101;
        2'd2:    ctl_nxt = 4'b1011;
        default: ctl_nxt = 4'b0111;
      endcase
      if (blank) ctl_nxt = 4'b1111;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      idx      <= 2'd0;
      act      <= 16'h0000;
      pend     <= 16'h0000;
      pv       <= 1'b0;
      load_ack <= 1'b0;
      bcd_sel  <= 4'h0;
      ssd_ctl  <= 4'b1110;
    end else begin
      cnt      <= cnt_nxt;
      idx      <= idx_nxt;
      act      <= act_nxt;
      pend     <= pend_nxt;
      pv       <= pv_nxt;
      load_ack <= commit;
      bcd_sel  <= sel_nxt;
      ssd_ctl  <= ctl_nxt;
    end
  end

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Scoreboarded bench for ssd_scan_ctrl: stimulus pushes expected per-cycle outputs, monitor compares.
module tb_ssd_scan_ctrl;

  localparam int DIV = 4;
  localparam int PER = 4 * DIV;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        load;
  logic [15:0] data_in;
  logic        busy;
  logic        load_ack;
  logic [3:0]  bcd_sel;
  logic [3:0]  ssd_ctl;

  ssd_scan_ctrl #(.REFRESH_DIV(DIV)) dut (
    .clk(clk), .rst(rst), .en(en), .load(load), .data_in(data_in),
    .busy(busy), .load_ack(load_ack), .bcd_sel(bcd_sel), .ssd_ctl(ssd_ctl)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       busy;
    logic       ack;
    logic [3:0] sel;
    logic [3:0] ctl;
  } rec_t;

  rec_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  // Reference model: scan position is simply the number of enabled cycles modulo one frame.
  int          m_pos;
  logic [15:0] m_act;
  logic [15:0] m_pend;
  logic        m_pv;
  logic        m_ack;
  logic [3:0]  m_sel;
  logic [3:0]  m_ctl;

  function automatic bit digit_lit(input int dig, input logic [15:0] a);
`ifdef SSD_LEADING_ZERO_BLANK_EN
    return (dig == 0) || ((a >> (4 * dig)) != 16'h0000);
`else
    return (dig >= 0) && (a === a);
`endif
  endfunction

  function automatic rec_t model_rec();
    rec_t r;
    r.busy = m_pv;
    r.ack  = m_ack;
    r.sel  = m_sel;
    r.ctl  = m_ctl;
    return r;
  endfunction

  task automatic model_reset();
    m_pos  = 0;
    m_act  = 16'h0000;
    m_pend = 16'h0000;
    m_pv   = 1'b0;
    m_ack  = 1'b0;
    m_sel  = 4'h0;
    m_ctl  = 4'b1110;
  endtask

  task automatic compare(input string name, input rec_t got, input rec_t want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got busy=%b ack=%b sel=%h ctl=%b, expected busy=%b ack=%b sel=%h ctl=%b",
               name, got.busy, got.ack, got.sel, got.ctl, want.busy, want.ack, want.sel, want.ctl);
    end
  endtask

  task automatic step(input logic e, input logic l, input logic [15:0] d);
    bit bnd;
    int dig;
    @(negedge clk);
    rst = 1'b0; en = e; load = l; data_in = d;
    bnd = e && (m_pos == PER - 1);
    m_ack = bnd && (l || m_pv);
    if (bnd && l) begin
      m_act = d;
      m_pv  = 1'b0;
    end else if (bnd && m_pv) begin
      m_act = m_pend;
      m_pv  = 1'b0;
    end else if (l) begin
      m_pend = d;
      m_pv   = 1'b1;
    end
    if (e) begin
      m_pos = (m_pos + 1) % PER;
      dig   = m_pos / DIV;
      m_sel = m_act[4*dig +: 4];
      m_ctl = digit_lit(dig, m_act) ? ~(4'b0001 << dig) : 4'b1111;
    end else begin
      m_ctl = 4'b1111;
    end
    exp_q.push_back(model_rec());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 16'h0000);
  endtask

  // Mid-cycle reset: outputs must clear before any clock edge arrives.
  task automatic do_reset();
    rec_t r;
    @(negedge clk);
    rst = 1'b1; load = 1'b0; en = 1'b1;
    #1;
    model_reset();
    r = {busy, load_ack, bcd_sel, ssd_ctl};
    compare("async_reset", r, model_rec());
    exp_q.push_back(model_rec());
  endtask

  initial begin : monitor
    rec_t got;
    rec_t want;
    forever begin
      @(posedge clk);
      #2;
      cyc++;
      got = {busy, load_ack, bcd_sel, ssd_ctl};
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL queue_underflow at cycle %0d: got sel=%h ctl=%b, expected a queued entry",
                 cyc, got.sel, got.ctl);
      end else begin
        want = exp_q.pop_front();
        compare($sformatf("cycle_%0d", cyc), got, want);
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    logic [15:0] d;
    int guard;
    rst = 1'b1; en = 1'b1; load = 1'b0; data_in = 16'h0000;
    model_reset();
    exp_q.push_back(model_rec());

    // Idle scan, then a load on the fifth cycle out of reset
    idle(4);
    step(1'b1, 1'b1, 16'h1234);
    idle(2 * PER);

    // Two loads inside one frame: last write wins, single ack
    guard = 0;
    while (m_pos != 2 && guard < PER) begin idle(1); guard++; end
    step(1'b1, 1'b1, 16'h1111);
    idle(4);
    step(1'b1, 1'b1, 16'h5678);
    idle(2 * PER);

    // Load exactly on the boundary cycle
    guard = 0;
    while (m_pos != PER - 1 && guard < PER) begin idle(1); guard++; end
    step(1'b1, 1'b1, 16'h9876);
    idle(PER + 2);

    // Disable mid-digit for 10 cycles, including a load while disabled
    guard = 0;
    while (m_pos % DIV != 1 && guard < PER) begin idle(1); guard++; end
    for (int i = 0; i < 10; i++) step(1'b0, (i == 4), 16'h4321);
    idle(2 * PER);

    // Leading-zero frames
    step(1'b1, 1'b1, 16'h0042);
    idle(2 * PER);
    step(1'b1, 1'b1, 16'h0000);
    idle(2 * PER);
    step(1'b1, 1'b1, 16'h0500);
    idle(2 * PER);

    // Randomized traffic with a mid-run reset discarding a pending frame
    for (int i = 0; i < 700; i++) begin
      d = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
      step($urandom_range(0, 9) != 0, $urandom_range(0, 11) == 0, d);
      if (i == 350) begin
        step(1'b1, 1'b1, 16'hABCD);
        do_reset();
      end
    end
    idle(PER);

    @(posedge clk);
    #4;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
